// File: rtl/apb_requester_pkg.sv
// Shared types and helpers for the queued APB4 requester.
//   state_e          : requester FSM state (IDLE=0, SETUP=1, ACCESS=2)
//   timeout_cnt_w()  : width of the ACCESS-phase watchdog counter
// The request/response payload structs live in apb_requester_q itself
// because their field widths follow the ADDR_WIDTH/DATA_WIDTH parameters
// of each instance.
package apb_requester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    // The counter only needs to reach TIMEOUT-1; keep at least one bit so the
    // declaration stays legal when the timeout is disabled or equals 1.
    function automatic int timeout_cnt_w(input int timeout);
        return (timeout >= 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/apb_requester_q_if.sv
// APB4 bus bundle between the requester and a completer.
//   master : drives paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb;
//            samples pready, prdata, pslverr
//   slave  : the mirror image, used by completers and bench models
interface apb_requester_q_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    pnse;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_sync_fifo.sv
// Generic synchronous FIFO with a registered-pointer, combinational-read
// storage array. Reset flushes the contents by clearing pointers and count.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write when push=1 and not full (push to a full FIFO is ignored)
//   pop/dout : dout shows the head entry; pop=1 and not empty removes it
//   full, empty, count : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module apb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/apb_requester_q.sv
// Queued APB4 requester. Local requests are buffered in a request FIFO and
// issued as back-to-back APB transfers; results return through a response
// FIFO. An optional ACCESS-phase watchdog aborts transfers to a hung completer.
//
// Ports:
//   pclk, preset       : clock, synchronous active-high reset
//   apb (master)       : APB4 bus, all outputs registered; pprot/pnse tied 0
//   req_*              : request channel {addr, wstrb, wdata}; wstrb==0 is a read
//   rsp_*              : response channel {rdata, slverr, timeout}
//   busy               : FSM active or requests still queued
//   dbg_state          : current FSM state
//
// Handshake: both local channels use valid/ready. A beat transfers on a
// rising edge where valid and ready are both 1. The producer holds valid and
// its payload stable until that edge; ready may be asserted independently of
// valid, and valid never waits on ready.
module apb_requester_q
    import apb_requester_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REQ_DEPTH  = 4,
    parameter int RSP_DEPTH  = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                    pclk,
    input  logic                    preset,
    apb_requester_q_if.master       apb,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic                    busy,
    output state_e                  dbg_state
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int QCW    = $clog2(REQ_DEPTH) + 1;
    localparam int RCW    = $clog2(RSP_DEPTH) + 1;
    localparam int TO_W   = timeout_cnt_w(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST  = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
    localparam logic [RCW-1:0]  RSP_LAST = RCW'(RSP_DEPTH - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [STRB_W-1:0]     wstrb;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } rsp_t;

    state_e          state;
    logic [TO_W-1:0] to_cnt;

    req_t            req_in;
    req_t            req_head;
    logic            req_push;
    logic            req_pop;
    logic            req_full;
    logic            req_empty;
    logic [QCW-1:0]  req_count;

    rsp_t            rsp_in;
    rsp_t            rsp_head;
    logic            rsp_push;
    logic            rsp_pop;
    logic            rsp_full;
    logic            rsp_empty;
    logic [RCW-1:0]  rsp_count;

    logic            expire;
    logic            done;
    logic            launch_idle;
    logic            launch_acc;
    logic            load;

    // Request side
    assign req_ready = !req_full && !preset;
    assign req_push  = req_valid && req_ready;
    assign req_in    = {req_addr, req_wstrb, req_wdata};

    apb_sync_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (req_push),
        .din   (req_in),
        .pop   (req_pop),
        .dout  (req_head),
        .full  (req_full),
        .empty (req_empty),
        .count (req_count)
    );

    // pready on the expiry cycle wins: that is a normal completion.
    assign expire = (TIMEOUT > 0) && (state == ACCESS) && !apb.pready && (to_cnt == TO_LAST);
    assign done   = (state == ACCESS) && (apb.pready || expire);

    // Launch credit ignores a same-cycle response pop. From ACCESS the
    // completing transfer's own response also needs a slot, hence DEPTH-1.
    assign launch_idle = (state == IDLE) && !req_empty && !rsp_full;
    assign launch_acc  = done && !req_empty && (rsp_count < RSP_LAST);
    assign load        = launch_idle || launch_acc;
    assign req_pop     = load;

    // Response side
    always_comb begin
        rsp_in = '0;
        if (expire) begin
            rsp_in.slverr  = 1'b1;
            rsp_in.timeout = 1'b1;
        end else begin
            rsp_in.rdata  = apb.pwrite ? '0 : apb.prdata;
            rsp_in.slverr = apb.pslverr;
        end
    end

    assign rsp_push = done;
    assign rsp_pop  = rsp_valid && rsp_ready;

    apb_sync_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (rsp_push),
        .din   (rsp_in),
        .pop   (rsp_pop),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    assign rsp_valid   = !rsp_empty;
    assign rsp_rdata   = rsp_head.rdata;
    assign rsp_slverr  = rsp_head.slverr;
    assign rsp_timeout = rsp_head.timeout;

    assign busy      = (state != IDLE) || (req_count != '0);
    assign dbg_state = state;

    assign apb.pprot = 3'b000;
    assign apb.pnse  = 1'b0;

    // FSM and registered APB outputs. A load (from IDLE or from a completing
    // ACCESS) takes priority and always lands in SETUP with psel held high.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            to_cnt      <= '0;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            apb.pstrb   <= '0;
        end else if (load) begin
            state       <= SETUP;
            to_cnt      <= '0;
            apb.psel    <= 1'b1;
            apb.penable <= 1'b0;
            apb.paddr   <= req_head.addr;
            apb.pwrite  <= |req_head.wstrb;
            apb.pstrb   <= req_head.wstrb;
            apb.pwdata  <= (|req_head.wstrb) ? req_head.wdata : '0;
        end else begin
            case (state)
                SETUP: begin
                    state       <= ACCESS;
                    apb.penable <= 1'b1;
                end
                ACCESS: begin
                    if (done) begin
                        state       <= IDLE;
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        apb.pwrite  <= 1'b0;
                        apb.paddr   <= '0;
                        apb.pwdata  <= '0;
                        apb.pstrb   <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
